uart_cmd_responder: RTL and testbench

- Sits between the UART receiver, the UART transmitter and the ALU inside top.
- Parses host command bytes and latches operand A, operand B and the opcode into ALU-facing registers.
- On the execute command, captures the ALU result and sends it back to the host through the transmitter, LSB byte first.
- This is the device-side responder for the host byte protocol: 0x01 = load A, 0x02 = load B, 0x03 = load op, 0x04 = execute and transmit.

---
 rtl/uart_cmd_responder.sv | 177 +++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
// Device-side command responder for the host byte protocol:
//   0x01 load A, 0x02 load B, 0x03 load op, 0x04 execute and transmit.
// Operand/opcode registers feed the ALU; on execute the ALU result is
// captured and streamed to the UART transmitter LSB byte first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a command byte
// S_WAIT_A | command 0x01 seen, next byte loads alu_a (timeout guarded)
// S_WAIT_B | command 0x02 seen, next byte loads alu_b (timeout guarded)
// S_WAIT_OP| command 0x03 seen, next byte loads alu_op (timeout guarded)
// S_SEND   | present result byte idx to the transmitter (one cycle)
// S_WAIT_TX| transmitter busy with byte idx, wait for tx_done_tick
module uart_cmd_responder #(
  parameter int N              = 8,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [7:0]      rx_data,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [N-1:0]    alu_result,
  output logic            busy,
  output logic            cmd_err
);

  localparam int NB = (N + 7) / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (N < 8) ? N : 8;

  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t          state_q, state_n;
  logic [N-1:0]    res_q, res_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [TW-1:0]   tmr_q, tmr_n;
  logic [N-1:0]    a_n, b_n;
  logic [OP_W-1:0] op_n;
  logic [7:0]      tx_data_n;
  logic            tx_start_n, busy_n, cmd_err_n;

  logic [8*NB-1:0] res_pad;
  logic [N-1:0]    val_ext;

  // State and every output are registered here; reset is immediate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state_q  <= state_n;
      res_q    <= res_n;
      idx_q    <= idx_n;
      tmr_q    <= tmr_n;
      alu_a    <= a_n;
      alu_b    <= b_n;
      alu_op   <= op_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      busy     <= busy_n;
      cmd_err  <= cmd_err_n;
    end
  end

  // Next-state and next-output decode; registers hold unless a state acts.
  always_comb begin
    state_n    = state_q;
    res_n      = res_q;
    idx_n      = idx_q;
    tmr_n      = tmr_q;
    a_n        = alu_a;
    b_n        = alu_b;
    op_n       = alu_op;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    cmd_err_n  = 1'b0;

    res_pad          = '0;
    res_pad[N-1:0]   = res_q;
    val_ext          = '0;
    val_ext[LW-1:0]  = rx_data[LW-1:0];

    case (state_q)
      S_IDLE: begin
        if (rx_done_tick) begin
          case (rx_data)
            8'h01: begin
              state_n = S_WAIT_A;
              tmr_n   = TMR_LOAD;
            end
            8'h02: begin
              state_n = S_WAIT_B;
              tmr_n   = TMR_LOAD;
            end
            8'h03: begin
              state_n = S_WAIT_OP;
              tmr_n   = TMR_LOAD;
            end
            8'h04: begin
              res_n   = alu_result;
              idx_n   = '0;
              state_n = S_SEND;
            end
            default: cmd_err_n = 1'b1;
          endcase
        end
      end

      S_WAIT_A, S_WAIT_B, S_WAIT_OP: begin
        if (rx_done_tick) begin
          // Value bytes are data even when they match a command code.
          if (state_q == S_WAIT_A)      a_n  = val_ext;
          else if (state_q == S_WAIT_B) b_n  = val_ext;
          else                          op_n = rx_data[OP_W-1:0];
          state_n = S_IDLE;
        end else if (tmr_q == '0) begin
          state_n   = S_IDLE;
          cmd_err_n = 1'b1;
        end else begin
          tmr_n = tmr_q - TW'(1);
        end
      end

      S_SEND: begin
        tx_start_n = 1'b1;
        tx_data_n  = res_pad[{idx_q, 3'b000} +: 8];
        state_n    = S_WAIT_TX;
        if (rx_done_tick) cmd_err_n = 1'b1;
      end

      S_WAIT_TX: begin
        if (tx_done_tick) begin
          if (idx_q == IDX_LAST) begin
            state_n = S_IDLE;
          end else begin
            idx_n   = idx_q + IW'(1);
            state_n = S_SEND;
          end
        end
        if (rx_done_tick) cmd_err_n = 1'b1;
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_SEND) || (state_n == S_WAIT_TX);
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: an 8-bit and a 16-bit instance
// share the same host byte stream and transmitter handshake.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done_tick = 1'b0;

  logic        tx_start8, busy8, cmd_err8;
  logic [7:0]  tx_data8, a8, b8, res8;
  logic [5:0]  op8;
  logic        tx_start16, busy16, cmd_err16;
  logic [7:0]  tx_data16;
  logic [15:0] a16, b16, res16;
  logic [5:0]  op16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU model: sum of the operands, opcode ignored.
  assign res8  = a8 + b8;
  assign res16 = a16 + b16;

  uart_cmd_responder #(.N(8), .OP_W(6), .TIMEOUT_CYCLES(100)) dut8 (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start8), .tx_data(tx_data8),
    .alu_a(a8), .alu_b(b8), .alu_op(op8), .alu_result(res8),
    .busy(busy8), .cmd_err(cmd_err8)
  );

  uart_cmd_responder #(.N(16), .OP_W(6), .TIMEOUT_CYCLES(100)) dut16 (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start16), .tx_data(tx_data16),
    .alu_a(a16), .alu_b(b16), .alu_op(op16), .alu_result(res16),
    .busy(busy16), .cmd_err(cmd_err16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx;
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  // Sends 0x04 and checks the two-cycle latency to the first tx_start.
  task automatic execute(input logic [7:0] exp8, input logic [7:0] exp16);
    send_byte(8'h04);
    check("lat_early8", tx_start8, 0);
    check("busy_send8", busy8, 1);
    @(negedge clk);
    check("tx_start8", tx_start8, 1);
    check("tx_data8", tx_data8, exp8);
    check("tx_start16", tx_start16, 1);
    check("tx_data16_lo", tx_data16, exp16);
  endtask

  // Completes the 8-bit single byte and both bytes of the 16-bit result.
  task automatic finish_tx16(input logic [7:0] exp_hi);
    pulse_tx;
    check("busy8_done", busy8, 0);
    check("busy16_mid", busy16, 1);
    @(negedge clk);
    check("tx_start16_hi", tx_start16, 1);
    check("tx_data16_hi", tx_data16, exp_hi);
    pulse_tx;
    check("busy16_done", busy16, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a8", a8, 0);
    check("rst_b8", b8, 0);
    check("rst_op8", op8, 0);
    check("rst_txd8", tx_data8, 0);
    check("rst_txs8", tx_start8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_err8", cmd_err8, 0);
    check("rst_a16", a16, 0);
    check("rst_busy16", busy16, 0);
    reset = 1'b0;
    pulse_tx;
    @(negedge clk);
    check("stray_done8", tx_start8, 0);
    check("stray_done16", tx_start16, 0);
    check("stray_busy8", busy8, 0);

    // Loads, command codes as data, single-byte execute
    send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h03); send_byte(8'h20);
    check("load_a8", a8, 8'h05);
    check("load_b8", b8, 8'h03);
    check("load_op8", op8, 6'h20);
    check("load_a16", a16, 16'h0005);
    check("load_op16", op16, 6'h20);
    execute(8'h08, 8'h08);
    @(negedge clk);
    check("pulse_one8", tx_start8, 0);
    check("hold_txd8", tx_data8, 8'h08);
    repeat (3) @(negedge clk);
    check("busy_hold8", busy8, 1);
    finish_tx16(8'h00);

    // Re-execute without reload resends the same result
    execute(8'h08, 8'h08);
    finish_tx16(8'h00);

    // Carry into the upper byte
    send_byte(8'h01); send_byte(8'hFF);
    send_byte(8'h02); send_byte(8'h01);
    check("load_ff8", a8, 8'hFF);
    check("load_ff16", a16, 16'h00FF);
    execute(8'h00, 8'h00);
    finish_tx16(8'h01);

    // Unknown command
    send_byte(8'h07);
    check("unk_err8", cmd_err8, 1);
    check("unk_err16", cmd_err16, 1);
    @(negedge clk);
    check("unk_pulse8", cmd_err8, 0);
    check("unk_a8", a8, 8'hFF);

    // Timeout after 100 cycles without a value byte
    send_byte(8'h01);
    repeat (99) @(negedge clk);
    check("to_early8", cmd_err8, 0);
    @(negedge clk);
    check("to_err8", cmd_err8, 1);
    check("to_err16", cmd_err16, 1);
    check("to_a8", a8, 8'hFF);
    send_byte(8'h02); send_byte(8'h07);
    check("to_idle_b8", b8, 8'h07);
    check("to_idle_a8", a8, 8'hFF);

    // Byte while busy is dropped
    execute(8'h06, 8'h06);
    send_byte(8'h01);
    check("busy_err8", cmd_err8, 1);
    check("busy_err16", cmd_err16, 1);
    check("busy_still8", busy8, 1);
    finish_tx16(8'h01);
    send_byte(8'h01); send_byte(8'h09);
    check("reload_a8", a8, 8'h09);
    check("reload_a16", a16, 16'h0009);

    // rx and tx_done in the same WAIT_TX cycle
    execute(8'h10, 8'h10);
    @(negedge clk);
    rx_data      = 8'h02;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    check("both_err8", cmd_err8, 1);
    check("both_busy8", busy8, 0);
    check("both_err16", cmd_err16, 1);
    check("both_busy16", busy16, 1);
    @(negedge clk);
    check("both_txs16", tx_start16, 1);
    check("both_txd16", tx_data16, 8'h00);
    pulse_tx;
    check("both_done16", busy16, 0);
    check("both_b8", b8, 8'h07);

    // Asynchronous reset during transmission
    execute(8'h10, 8'h10);
    #1 reset = 1'b1;
    #1;
    check("arst_txs8", tx_start8, 0);
    check("arst_busy8", busy8, 0);
    check("arst_txd8", tx_data8, 0);
    check("arst_a8", a8, 0);
    check("arst_b8", b8, 0);
    check("arst_op8", op8, 0);
    check("arst_txs16", tx_start16, 0);
    check("arst_busy16", busy16, 0);
    @(negedge clk);
    reset = 1'b0;
    execute(8'h00, 8'h00);
    finish_tx16(8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
